fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch stage that owns the program counter, issues single-outstanding requests to the instruction cache, and presents `{pc_n, inst}` to the IF/ID pipeline latch. It sits directly upstream of the IF/ID latch. It absorbs cache latency, stalls from the hazard/control logic, and jump redirects from EX. A one-entry skid buffer keeps in-flight returns from being lost while the stage is stalled.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.
- `XLEN`, default 32: address and instruction width.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `stall`  in  1  IF/ID latch will not accept this cycle.
- `redirect`  in  1  taken jump/branch resolved in EX.
- `redirect_pc`  in  XLEN  jump target; bits [1:0] are ignored and treated as 0.
- `imem_req`  out  1  request to the instruction cache.
- `imem_addr`  out  XLEN  word-aligned fetch address.
- `imem_ack`  in  1  one-cycle response strobe; `imem_rdata` is valid in the same cycle.
- `imem_rdata`  in  XLEN  instruction word.
- `valid`  out  1  `inst` and `pc_n` hold a live instruction.
- `inst`  out  XLEN  instruction word to the IF/ID latch.
- `pc_n`  out  XLEN  fetch address + 4 of `inst`.

## Operation
- **Memory protocol.**
  - At most one request is outstanding.
  - `imem_req` and `imem_addr` stay stable until `imem_ack`.
  - An ack in the same cycle as the request is legal.
- **Consume rule.** The consumer takes the output when `valid && !stall`.
- **FSM states:**
  - IDLE:
    - Entered on reset; `imem_req`=0.
    - Moves to REQ next cycle.
    - An `imem_ack` seen here is ignored.
  - REQ: `imem_req`=1, `imem_addr`=`pc`.
    - ack, no redirect: data goes to the output register if it is empty or being consumed, otherwise to the skid buffer. `pc`<=`pc`+4 (wraps 0xFFFF_FFFC -> 0). If the skid buffer is now full, go to FULL.
    - ack with redirect: discard the data, `pc`<=`redirect_pc`, stay in REQ.
    - redirect, no ack: latch the target, go to DROP.
  - DROP: `imem_req`=1 with the old address; this keeps the protocol legal.
    - On ack: discard the data, `pc`<=latched target, go to REQ.
    - A further redirect in DROP overwrites the latched target.
  - FULL: `imem_req`=0.
    - When the output is consumed, skid moves to output and the state goes to REQ.
    - redirect: `pc`<=`redirect_pc`, go to REQ.
- **Redirect.** In any state, `redirect` clears output `valid` and the skid buffer on the next edge. Redirect has priority over `stall`.
- **Stall.** While `stall`=1 and no redirect, `inst`/`pc_n`/`valid` hold their values.
- **Reset values:** `valid`=0, `inst`=0, `pc_n`=0, `imem_req`=0, `imem_addr`=`RESET_PC`, skid empty, state IDLE, `pc`=`RESET_PC`.
- The instruction cache is reset by the same `rst`, so no stale ack survives reset. Reset mid-request simply abandons the request.

## Timing
- First request: the cycle after `rst` deasserts (IDLE -> REQ).
- Ack-to-`valid`: 1 cycle, registered output.
- Throughput with a zero-wait cache and no stall: one instruction per cycle.
  - While in REQ, the next request's address updates on the same edge as the ack.
- Redirect-to-new-request:
  - 1 cycle if no request is pending, or the pending one acks in the redirect cycle.
  - Otherwise, 1 cycle after the dropped ack.
- With a full skid buffer, the stall-release cycle moves skid to output; the next request issues one cycle later.

## Structure
- Package `fetch_pkg` holds:
  - the state enum (IDLE, REQ, DROP, FULL);
  - `RESET_PC` default;
  - the `PC_STEP` constant (4).
- One sub-module: `fetch_skid`, a one-entry `{pc_n, inst}` buffer with `push`, `pop`, `flush`, `full`.
- PC, FSM and output register live in `fetch_unit`.

## Test plan
- **Reset and zero-wait streaming.** Release reset, `imem_ack` same cycle as every req, RESET_PC=0.
  - `imem_addr` goes 0,4,8,...
  - `valid` rises 2 cycles after reset release.
  - `pc_n` goes 4,8,12 with matching `inst`.
- **Stall with in-flight return.** Hold `stall` 3 cycles while an ack arrives.
  - Output is frozen and the skid buffer captures the word.
  - `imem_req` drops (FULL).
  - After release, the skid word appears with no gap and no duplicate.
- **Redirect during pending request.** Pending addr 0x10, 3-cycle cache latency, `redirect` to 0x200 in the wait.
  - `imem_addr` stays 0x10 until ack and that data never reaches `valid`.
  - The next request is 0x200; `pc_n`=0x204.
- **Redirect coincident with ack and stall.** `redirect`=1, `stall`=1, `imem_ack`=1 together, target 0x43 (misaligned).
  - `valid`=0 next cycle.
  - The next `imem_addr`=0x40.
- **Wrap and mid-operation reset.**
  - Redirect to 0xFFFF_FFFC: the next address is 0x0.
  - Asserting `rst` during DROP returns all outputs to their reset values and the next request is `RESET_PC`.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared state type and constants for the instruction-fetch stage
package fetch_pkg;
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DROP, S_FULL} fetch_state_e;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam int PC_STEP = 4;
endpackage

// File: rtl/fetch_skid.sv
// fetch_skid: one-entry {pc_n, inst} buffer that catches a return while the output is stalled
module fetch_skid
    import fetch_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic            pop,
    input  logic            flush,
    input  logic [XLEN-1:0] i_pc_n,
    input  logic [XLEN-1:0] i_inst,
    output logic            full,
    output logic [XLEN-1:0] o_pc_n,
    output logic [XLEN-1:0] o_inst
);
    logic            r_full;
    logic [XLEN-1:0] r_pc_n;
    logic [XLEN-1:0] r_inst;
    assign full   = r_full;
    assign o_pc_n = r_pc_n;
    assign o_inst = r_inst;
    // flush empties the entry outright; otherwise push fills it and pop drains it
    always_ff @(posedge clk) begin
        if (rst) begin
            r_full <= 1'b0;
            r_pc_n <= '0;
            r_inst <= '0;
        end else begin
            r_full <= !flush && (push || (r_full && !pop));
            if (push) begin
                r_pc_n <= i_pc_n;
                r_inst <= i_inst;
            end
        end
    end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: owns the PC, issues single-outstanding imem requests, feeds the IF/ID latch
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            valid,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] pc_n
);
    fetch_state_e    r_state;
    fetch_state_e    w_state_nx;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] w_pc_nx;
    logic [XLEN-1:0] r_target;
    logic [XLEN-1:0] w_target_nx;
    logic            r_valid;
    logic [XLEN-1:0] r_inst;
    logic [XLEN-1:0] r_pc_n;
    logic [XLEN-1:0] w_redirect_pc;
    logic [XLEN-1:0] w_pc_inc;
    logic [XLEN-1:0] w_skid_pc_n;
    logic [XLEN-1:0] w_skid_inst;
    logic            w_skid_full;
    logic            w_open;
    logic            w_accept;
    logic            w_push;
    logic            w_pop;

    assign w_redirect_pc = redirect_pc & ~XLEN'(3);
    assign w_pc_inc      = r_pc + XLEN'(PC_STEP);
    assign w_open        = !r_valid || !stall;
    assign w_accept      = (r_state == S_REQ) && imem_ack && !redirect;
    assign w_push        = w_accept && !w_open;
    assign w_pop         = w_skid_full && w_open && !redirect;

    assign imem_req  = (r_state == S_REQ) || (r_state == S_DROP);
    assign imem_addr = r_pc;
    assign valid     = r_valid;
    assign inst      = r_inst;
    assign pc_n      = r_pc_n;

    fetch_skid #(.XLEN(XLEN)) u_skid (
        .clk    (clk),
        .rst    (rst),
        .push   (w_push),
        .pop    (w_pop),
        .flush  (redirect),
        .i_pc_n (w_pc_inc),
        .i_inst (imem_rdata),
        .full   (w_skid_full),
        .o_pc_n (w_skid_pc_n),
        .o_inst (w_skid_inst)
    );

    // state, PC and latched redirect target
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_pc     <= RESET_PC;
            r_target <= RESET_PC;
        end else begin
            r_state  <= w_state_nx;
            r_pc     <= w_pc_nx;
            r_target <= w_target_nx;
        end
    end

    // next state: a pending request must complete before a redirect target is fetched
    always_comb begin
        w_state_nx  = r_state;
        w_pc_nx     = r_pc;
        w_target_nx = r_target;
        case (r_state)
            S_IDLE: begin
                w_state_nx = S_REQ;
                w_pc_nx    = redirect ? w_redirect_pc : r_pc;
            end
            S_REQ: begin
                if (imem_ack) begin
                    w_pc_nx    = redirect ? w_redirect_pc : w_pc_inc;
                    w_state_nx = w_push ? S_FULL : S_REQ;
                end else if (redirect) begin
                    w_target_nx = w_redirect_pc;
                    w_state_nx  = S_DROP;
                end
            end
            S_DROP: begin
                w_target_nx = redirect ? w_redirect_pc : r_target;
                if (imem_ack) begin
                    w_pc_nx    = redirect ? w_redirect_pc : r_target;
                    w_state_nx = S_REQ;
                end
            end
            S_FULL: begin
                w_pc_nx    = redirect ? w_redirect_pc : r_pc;
                w_state_nx = (redirect || w_pop) ? S_REQ : S_FULL;
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    // output register: redirect flushes, stall holds, otherwise skid entry beats a fresh return
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_inst  <= '0;
            r_pc_n  <= '0;
        end else if (redirect) begin
            r_valid <= 1'b0;
        end else if (w_open) begin
            r_valid <= w_skid_full || w_accept;
            if (w_skid_full) begin
                r_pc_n <= w_skid_pc_n;
                r_inst <= w_skid_inst;
            end else if (w_accept) begin
                r_pc_n <= w_pc_inc;
                r_inst <= imem_rdata;
            end
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenarios plus a randomized program-order scoreboard for fetch_unit
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        valid;
    logic [31:0] inst;
    logic [31:0] pc_n;
    int          n_checks = 0;
    int          n_errors = 0;

    fetch_unit #(.XLEN(32), .RESET_PC(32'h0)) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .valid       (valid),
        .inst        (inst),
        .pc_n        (pc_n)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return {a[7:0], a[31:8]} ^ 32'h5A3C_96E1;
    endfunction

    task automatic zero_wait();
        imem_ack   = imem_req;
        imem_rdata = mem(imem_addr);
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst = 1'b1;
        stall = 1'b0;
        redirect = 1'b0;
        redirect_pc = '0;
        imem_ack = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic stream_to(input int k);
        for (int i = 1; i <= k; i++) begin
            @(negedge clk);
            if (i < k) zero_wait();
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        imem_ack = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({valid, inst, pc_n} !== 65'h0) begin
            n_errors++;
            $display("FAIL reset_out got v=%b inst=%h pc_n=%h expected all zero", valid, inst, pc_n);
        end
        n_checks++;
        if ({imem_req, imem_addr} !== 33'h0) begin
            n_errors++;
            $display("FAIL reset_req got req=%b addr=%h expected 0/00000000", imem_req, imem_addr);
        end
        imem_ack = 1'b0;
    endtask

    task automatic test_stream();
        release_reset();
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            n_checks++;
            if ({imem_req, imem_addr} !== {1'b1, 32'(4 * (k - 1))}) begin
                n_errors++;
                $display("FAIL stream_addr k=%0d got req=%b addr=%h expected addr %h", k, imem_req, imem_addr, 32'(4 * (k - 1)));
            end
            n_checks++;
            if (valid !== (k >= 2)) begin
                n_errors++;
                $display("FAIL stream_valid k=%0d got %b expected %b", k, valid, k >= 2);
            end
            if (k >= 2) begin
                n_checks++;
                if ({pc_n, inst} !== {32'(4 * (k - 1)), mem(32'(4 * (k - 2)))}) begin
                    n_errors++;
                    $display("FAIL stream_data k=%0d got pc_n=%h inst=%h expected pc_n=%h", k, pc_n, inst, 32'(4 * (k - 1)));
                end
            end
            zero_wait();
        end
    endtask

    task automatic test_stall();
        release_reset();
        stream_to(4);
        stall = 1'b1;
        zero_wait();
        for (int k = 5; k <= 7; k++) begin
            @(negedge clk);
            if (k == 7) stall = 1'b0;
            n_checks++;
            if ({valid, pc_n, inst, imem_req} !== {1'b1, 32'd12, mem(32'd8), 1'b0}) begin
                n_errors++;
                $display("FAIL stall_hold k=%0d got v=%b pc_n=%h req=%b expected v=1 pc_n=0000000c req=0", k, valid, pc_n, imem_req);
            end
            zero_wait();
        end
        @(negedge clk);
        n_checks++;
        if ({valid, pc_n, inst, imem_req, imem_addr} !== {1'b1, 32'd16, mem(32'd12), 1'b1, 32'd16}) begin
            n_errors++;
            $display("FAIL stall_skid got v=%b pc_n=%h inst=%h req=%b addr=%h expected pc_n=00000010 addr=00000010", valid, pc_n, inst, imem_req, imem_addr);
        end
        zero_wait();
        @(negedge clk);
        n_checks++;
        if ({valid, pc_n, inst} !== {1'b1, 32'd20, mem(32'd16)}) begin
            n_errors++;
            $display("FAIL stall_next got v=%b pc_n=%h inst=%h expected pc_n=00000014", valid, pc_n, inst);
        end
    endtask

    task automatic test_redirect_pending();
        release_reset();
        stream_to(5);
        imem_ack = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h10}) begin
            n_errors++;
            $display("FAIL pend_addr got req=%b addr=%h expected 1/00000010", imem_req, imem_addr);
        end
        redirect = 1'b1;
        redirect_pc = 32'h200;
        for (int k = 7; k <= 8; k++) begin
            @(negedge clk);
            redirect = 1'b0;
            n_checks++;
            if ({imem_req, imem_addr, valid} !== {1'b1, 32'h10, 1'b0}) begin
                n_errors++;
                $display("FAIL pend_drop k=%0d got req=%b addr=%h v=%b expected 1/00000010/0", k, imem_req, imem_addr, valid);
            end
        end
        imem_ack = 1'b1;
        imem_rdata = mem(32'h10);
        @(negedge clk);
        n_checks++;
        if ({imem_req, imem_addr, valid} !== {1'b1, 32'h200, 1'b0}) begin
            n_errors++;
            $display("FAIL pend_new got req=%b addr=%h v=%b expected 1/00000200/0", imem_req, imem_addr, valid);
        end
        zero_wait();
        @(negedge clk);
        n_checks++;
        if ({valid, pc_n, inst} !== {1'b1, 32'h204, mem(32'h200)}) begin
            n_errors++;
            $display("FAIL pend_data got v=%b pc_n=%h inst=%h expected pc_n=00000204", valid, pc_n, inst);
        end
    endtask

    task automatic test_redirect_ack_stall();
        release_reset();
        stream_to(4);
        redirect = 1'b1;
        stall = 1'b1;
        redirect_pc = 32'h43;
        zero_wait();
        @(negedge clk);
        redirect = 1'b0;
        stall = 1'b0;
        n_checks++;
        if ({valid, imem_req, imem_addr} !== {1'b0, 1'b1, 32'h40}) begin
            n_errors++;
            $display("FAIL ras_flush got v=%b req=%b addr=%h expected 0/1/00000040", valid, imem_req, imem_addr);
        end
        zero_wait();
        @(negedge clk);
        n_checks++;
        if ({valid, pc_n, inst} !== {1'b1, 32'h44, mem(32'h40)}) begin
            n_errors++;
            $display("FAIL ras_data got v=%b pc_n=%h inst=%h expected pc_n=00000044", valid, pc_n, inst);
        end
    endtask

    task automatic test_wrap_reset();
        release_reset();
        stream_to(3);
        redirect = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        zero_wait();
        @(negedge clk);
        redirect = 1'b0;
        n_checks++;
        if ({imem_req, imem_addr, valid} !== {1'b1, 32'hFFFF_FFFC, 1'b0}) begin
            n_errors++;
            $display("FAIL wrap_top got req=%b addr=%h v=%b expected 1/fffffffc/0", imem_req, imem_addr, valid);
        end
        zero_wait();
        @(negedge clk);
        n_checks++;
        if ({imem_addr, valid, pc_n, inst} !== {32'h0, 1'b1, 32'h0, mem(32'hFFFF_FFFC)}) begin
            n_errors++;
            $display("FAIL wrap_zero got addr=%h v=%b pc_n=%h inst=%h expected addr=0 pc_n=0", imem_addr, valid, pc_n, inst);
        end
        zero_wait();
        @(negedge clk);
        n_checks++;
        if ({imem_addr, pc_n, inst} !== {32'h4, 32'h4, mem(32'h0)}) begin
            n_errors++;
            $display("FAIL wrap_next got addr=%h pc_n=%h inst=%h expected 00000004/00000004", imem_addr, pc_n, inst);
        end
        imem_ack = 1'b0;
        redirect = 1'b1;
        redirect_pc = 32'h300;
        @(negedge clk);
        redirect = 1'b0;
        n_checks++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h4}) begin
            n_errors++;
            $display("FAIL drop_hold got req=%b addr=%h expected 1/00000004", imem_req, imem_addr);
        end
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({valid, inst, pc_n, imem_req, imem_addr} !== 98'h0) begin
            n_errors++;
            $display("FAIL drop_reset got v=%b inst=%h pc_n=%h req=%b addr=%h expected all zero", valid, inst, pc_n, imem_req, imem_addr);
        end
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({imem_req, imem_addr, valid} !== {1'b1, 32'h0, 1'b0}) begin
            n_errors++;
            $display("FAIL drop_restart got req=%b addr=%h v=%b expected 1/00000000/0", imem_req, imem_addr, valid);
        end
    endtask

    task automatic test_random();
        logic [31:0] exp_pc = 32'h0;
        logic [31:0] req_addr = 32'h0;
        bit          busy = 1'b0;
        int          wait_left = 0;
        int          consumed = 0;
        release_reset();
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            if (busy) begin
                n_checks++;
                if ({imem_req, imem_addr} !== {1'b1, req_addr}) begin
                    n_errors++;
                    $display("FAIL rand_proto c=%0d got req=%b addr=%h expected 1/%h", c, imem_req, imem_addr, req_addr);
                end
            end
            stall = ($urandom_range(0, 99) < 30);
            redirect = ($urandom_range(0, 99) < 4);
            redirect_pc = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15)) : $urandom;
            if (redirect) begin
                exp_pc = redirect_pc & ~32'h3;
            end else if (valid && !stall) begin
                n_checks++;
                if ({pc_n, inst} !== {exp_pc + 32'd4, mem(exp_pc)}) begin
                    n_errors++;
                    $display("FAIL rand_stream c=%0d got pc_n=%h inst=%h expected pc_n=%h inst=%h", c, pc_n, inst, exp_pc + 32'd4, mem(exp_pc));
                end
                exp_pc += 32'd4;
                consumed++;
            end
            if (imem_req && !busy) begin
                busy = 1'b1;
                wait_left = $urandom_range(0, 3);
                req_addr = imem_addr;
            end
            imem_ack = busy && (wait_left == 0);
            imem_rdata = imem_ack ? mem(imem_addr) : $urandom;
            if (busy) begin
                if (wait_left == 0) busy = 1'b0;
                else wait_left--;
            end
        end
        redirect = 1'b0;
        stall = 1'b0;
        imem_ack = 1'b0;
        n_checks++;
        if (consumed < 200) begin
            n_errors++;
            $display("FAIL rand_progress got %0d consumed expected at least 200", consumed);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect_pending();
        test_redirect_ack_stall();
        test_wrap_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
